wb_arbiter: RTL and testbench

Writeback arbiter and register scoreboard: the producer side of the integer register file's single write port. Accepts completed results from the execute unit (EXU) and load/store unit (LSU) over valid/ready, arbitrates round-robin, and registers one write per cycle onto the register file's `wen`/`addr`/`wdata` port. Keeps a per-register busy vector, set at issue and cleared at writeback, so decode can stall on RAW and WAW hazards.

---
 rtl/wb_arbiter_pkg.sv | 13 +
 rtl/wb_arbiter_if.sv | 44 ++++
 rtl/wb_arbiter_scoreboard.sv | 44 ++++
 rtl/wb_arbiter.sv | 71 +++++++
 tb/tb_wb_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizes for the writeback arbiter.
// Result request bundle used by the EXU and LSU ports.
package wb_arbiter_pkg;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between decode, EXU, LSU and the writeback arbiter.
// master drives requests, slave is the arbiter side.
import wb_arbiter_pkg::*;

interface wb_arbiter_if;
  logic            issue_valid_i;
  logic [AW-1:0]   issue_rd_i;
  logic            issue_ready_o;
  logic            exu_valid_i;
  logic [AW-1:0]   exu_rd_i;
  logic [XLEN-1:0] exu_data_i;
  logic            exu_ready_o;
  logic            lsu_valid_i;
  logic [AW-1:0]   lsu_rd_i;
  logic [XLEN-1:0] lsu_data_i;
  logic            lsu_ready_o;
  logic [AW-1:0]   rs1_addr_i;
  logic [AW-1:0]   rs2_addr_i;
  logic            rs1_busy_o;
  logic            rs2_busy_o;
  logic            wen_o;
  logic [AW-1:0]   addr_o;
  logic [XLEN-1:0] wdata_o;

  modport master (
    output issue_valid_i, issue_rd_i,
    output exu_valid_i, exu_rd_i, exu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output rs1_addr_i, rs2_addr_i,
    input  issue_ready_o, exu_ready_o, lsu_ready_o,
    input  rs1_busy_o, rs2_busy_o,
    input  wen_o, addr_o, wdata_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_i,
    input  exu_valid_i, exu_rd_i, exu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  rs1_addr_i, rs2_addr_i,
    output issue_ready_o, exu_ready_o, lsu_ready_o,
    output rs1_busy_o, rs2_busy_o,
    output wen_o, addr_o, wdata_o
  );
endinterface

// File: rtl/wb_arbiter_scoreboard.sv
// Per-register pending-write vector for RAW/WAW stalls.
// A write in flight is bypassed, so it is not reported busy.
import wb_arbiter_pkg::*;

module wb_scoreboard (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          rs1_busy,
  output logic          rs2_busy
);
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_n;
  logic            set_en;

  // Query ports: pending and not being written this cycle
  always_comb begin
    rs1_busy    = busy[rs1] & ~(clr_en & (clr_rd == rs1));
    rs2_busy    = busy[rs2] & ~(clr_en & (clr_rd == rs2));
    issue_ready = (issue_rd == '0) | ~busy[issue_rd] |
                  (clr_en & (clr_rd == issue_rd));
    set_en      = issue_valid & issue_ready & (issue_rd != '0);
  end

  // Next busy vector: clear first so a same-cycle set wins
  always_comb begin
    busy_n = busy;
    if (clr_en) busy_n[clr_rd] = 1'b0;
    if (set_en) busy_n[issue_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_n;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter feeding the regfile write port.
// The scoreboard tracks destinations pending writeback.
import wb_arbiter_pkg::*;

module wb_arbiter (
  input  logic clk,
  input  logic rst,
  wb_arbiter_if.slave bus
);
  wb_req_t         exu_req;
  wb_req_t         lsu_req;
  wb_req_t         sel;
  logic            last_lsu;
  logic            contest;
  logic            gnt_exu;
  logic            gnt_lsu;
  logic            wen;
  logic [AW-1:0]   addr;
  logic [XLEN-1:0] wdata;

  assign exu_req = {bus.exu_valid_i, bus.exu_rd_i, bus.exu_data_i};
  assign lsu_req = {bus.lsu_valid_i, bus.lsu_rd_i, bus.lsu_data_i};

  // Grant: sole requester wins; on contest the one not granted last
  always_comb begin
    contest = exu_req.valid & lsu_req.valid;
    gnt_lsu = lsu_req.valid & (~exu_req.valid | ~last_lsu);
    gnt_exu = exu_req.valid & ~gnt_lsu;
    sel     = gnt_lsu ? lsu_req : exu_req;
  end

  assign bus.exu_ready_o = gnt_exu;
  assign bus.lsu_ready_o = gnt_lsu;

  // Fairness flag and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_lsu <= 1'b0;
      wen      <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
    end else begin
      if (contest) last_lsu <= ~last_lsu;
      if (sel.valid) begin
        wen   <= (sel.rd != '0);
        addr  <= sel.rd;
        wdata <= sel.data;
      end else begin
        wen   <= 1'b0;
      end
    end
  end

  assign bus.wen_o   = wen;
  assign bus.addr_o  = addr;
  assign bus.wdata_o = wdata;

  wb_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (bus.issue_valid_i),
    .issue_rd    (bus.issue_rd_i),
    .issue_ready (bus.issue_ready_o),
    .clr_en      (wen),
    .clr_rd      (addr),
    .rs1         (bus.rs1_addr_i),
    .rs2         (bus.rs2_addr_i),
    .rs1_busy    (bus.rs1_busy_o),
    .rs2_busy    (bus.rs2_busy_o)
  );
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter.
// Inputs change 1ns after posedge; outputs sampled mid-cycle.
import wb_arbiter_pkg::*;

module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = '0;
    bus.exu_valid_i   = 1'b0;
    bus.exu_rd_i      = '0;
    bus.exu_data_i    = '0;
    bus.lsu_valid_i   = 1'b0;
    bus.lsu_rd_i      = '0;
    bus.lsu_data_i    = '0;
  endtask

  logic [4:0]  e_rd [2] = '{5'd10, 5'd11};
  logic [63:0] e_dt [2] = '{64'hE0, 64'hE1};
  logic [4:0]  l_rd [2] = '{5'd20, 5'd21};
  logic [63:0] l_dt [2] = '{64'hA0, 64'hA1};
  logic        x_lsu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [4:0]  x_rd [4] = '{5'd20, 5'd10, 5'd21, 5'd11};
  logic [63:0] x_dt [4] = '{64'hA0, 64'hE0, 64'hA1, 64'hE1};

  initial begin
    int ei;
    int li;
    idle();
    bus.rs1_addr_i = '0;
    bus.rs2_addr_i = '0;
    #12;
    chk("rst_wen", bus.wen_o, 0);
    chk("rst_addr", bus.addr_o, 0);
    chk("rst_wdata", bus.wdata_o, 0);
    rst = 1'b0;
    step();

    bus.exu_valid_i = 1'b1;
    bus.exu_rd_i    = 5'd5;
    bus.exu_data_i  = 64'h1234;
    #1;
    chk("exu_ready", bus.exu_ready_o, 1);
    chk("lsu_ready_idle", bus.lsu_ready_o, 0);
    step();
    idle();
    chk("wb1_wen", bus.wen_o, 1);
    chk("wb1_addr", bus.addr_o, 5);
    chk("wb1_wdata", bus.wdata_o, 64'h1234);
    step();
    chk("wb1_wen_drop", bus.wen_o, 0);
    chk("wb1_addr_hold", bus.addr_o, 5);
    chk("wb1_wdata_hold", bus.wdata_o, 64'h1234);

    ei = 0;
    li = 0;
    for (int c = 0; c < 4; c++) begin
      bus.exu_valid_i = 1'b1;
      bus.exu_rd_i    = e_rd[ei];
      bus.exu_data_i  = e_dt[ei];
      bus.lsu_valid_i = 1'b1;
      bus.lsu_rd_i    = l_rd[li];
      bus.lsu_data_i  = l_dt[li];
      #1;
      chk($sformatf("rr_lsu_rdy%0d", c), bus.lsu_ready_o, x_lsu[c]);
      chk($sformatf("rr_exu_rdy%0d", c), bus.exu_ready_o, !x_lsu[c]);
      step();
      chk($sformatf("rr_wen%0d", c), bus.wen_o, 1);
      chk($sformatf("rr_addr%0d", c), bus.addr_o, x_rd[c]);
      chk($sformatf("rr_data%0d", c), bus.wdata_o, x_dt[c]);
      if (x_lsu[c]) li = (li < 1) ? li + 1 : 1;
      else          ei = (ei < 1) ? ei + 1 : 1;
    end
    idle();
    step();
    chk("rr_done_wen", bus.wen_o, 0);

    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd7;
    #1;
    chk("iss7_ready", bus.issue_ready_o, 1);
    step();
    bus.issue_valid_i = 1'b0;
    bus.rs1_addr_i    = 5'd7;
    bus.rs2_addr_i    = 5'd8;
    #1;
    chk("rs1_busy7", bus.rs1_busy_o, 1);
    chk("rs2_idle8", bus.rs2_busy_o, 0);
    chk("waw_stall", bus.issue_ready_o, 0);
    bus.exu_valid_i = 1'b1;
    bus.exu_rd_i    = 5'd7;
    bus.exu_data_i  = 64'h77;
    step();
    bus.exu_valid_i   = 1'b0;
    bus.issue_valid_i = 1'b1;
    #1;
    chk("wb7_wen", bus.wen_o, 1);
    chk("wb7_bypass", bus.rs1_busy_o, 0);
    chk("wb7_iss_ready", bus.issue_ready_o, 1);
    step();
    bus.issue_valid_i = 1'b0;
    #1;
    chk("set_wins", bus.rs1_busy_o, 1);
    bus.exu_valid_i = 1'b1;
    step();
    bus.exu_valid_i = 1'b0;
    step();
    chk("x7_cleared", bus.rs1_busy_o, 0);

    bus.exu_valid_i = 1'b1;
    bus.exu_rd_i    = 5'd0;
    bus.exu_data_i  = 64'hFF;
    #1;
    chk("x0_ready", bus.exu_ready_o, 1);
    step();
    idle();
    chk("x0_no_wen", bus.wen_o, 0);
    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd0;
    #1;
    chk("iss0_ready", bus.issue_ready_o, 1);
    step();
    bus.issue_valid_i = 1'b0;
    bus.rs1_addr_i    = 5'd0;
    #1;
    chk("x0_not_busy", bus.rs1_busy_o, 0);

    bus.issue_valid_i = 1'b1;
    bus.issue_rd_i    = 5'd3;
    step();
    bus.issue_rd_i = 5'd4;
    step();
    bus.issue_rd_i = 5'd6;
    step();
    bus.issue_valid_i = 1'b0;
    bus.exu_valid_i   = 1'b1;
    bus.exu_rd_i      = 5'd9;
    bus.exu_data_i    = 64'hBEEF;
    step();
    idle();
    bus.rs1_addr_i = 5'd3;
    bus.rs2_addr_i = 5'd4;
    bus.issue_rd_i = 5'd6;
    #1;
    chk("pre_rst_wen", bus.wen_o, 1);
    chk("pre_rst_busy3", bus.rs1_busy_o, 1);
    chk("pre_rst_busy4", bus.rs2_busy_o, 1);
    chk("pre_rst_busy6", bus.issue_ready_o, 0);
    rst = 1'b1;
    #1;
    chk("arst_wen", bus.wen_o, 0);
    chk("arst_addr", bus.addr_o, 0);
    chk("arst_wdata", bus.wdata_o, 0);
    chk("arst_busy3", bus.rs1_busy_o, 0);
    chk("arst_busy4", bus.rs2_busy_o, 0);
    chk("arst_busy6", bus.issue_ready_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
